decoder9_route_inject: RTL

Clocked packet-injection stage directly upstream of the 9-bit leaf decoder. Accepts 9-bit flits with a packet-last marker from a synchronous source. Extracts the route-select bit from each packet's header flit and emits every flit of that packet together with that select bit on a shared 9+1-bit output. The output pairs with the decoder's `In` (9-bit) and `S` (1-bit) channels through the clocked-to-async bridge. A 2-entry output FIFO decouples source and bridge.

---
 rtl/decoder9_route_inject.sv | 126 ++++++++++++
 1 files changed

// File: rtl/decoder9_route_inject.sv
// rtl/decoder9_route_inject.sv - header-select route injector with 2-entry output FIFO
// Optional packet statistics counters are enabled by defining ROUTE_INJECT_STATS_EN.
module decoder9_route_inject #(
  parameter int W       = 9,
  parameter int SEL_BIT = 0,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     out_data,
  output logic             out_sel,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);

  typedef enum logic {HEAD = 1'b0, BODY = 1'b1} state_t;

  state_t       state;
  logic         sel_q;
  logic [W-1:0] mem_data [2];
  logic         mem_sel  [2];
  logic         mem_last [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;

  logic         push;
  logic         pop;
  logic         push_sel;

  // in_ready depends only on the registered occupancy, never on out_ready
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // header flits carry their own select bit; body flits reuse the latched one
  assign push_sel  = (state == HEAD) ? in_data[SEL_BIT] : sel_q;

  assign out_data  = mem_data[rd_ptr];
  assign out_sel   = mem_sel[rd_ptr];
  assign out_last  = mem_last[rd_ptr];

  // packet framing FSM: latch the route select from each header flit
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= HEAD;
      sel_q <= 1'b0;
    end else if (push) begin
      case (state)
        HEAD: begin
          sel_q <= in_data[SEL_BIT];
          state <= in_last ? HEAD : BODY;
        end
        BODY: begin
          state <= in_last ? HEAD : BODY;
        end
        default: state <= HEAD;
      endcase
    end
  end

  // FIFO storage, pointers and occupancy; simultaneous push/pop keeps count
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 2; i++) begin
        mem_data[i] <= '0;
        mem_sel[i]  <= 1'b0;
        mem_last[i] <= 1'b0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= in_data;
        mem_sel[wr_ptr]  <= push_sel;
        mem_last[wr_ptr] <= in_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push && !pop) begin
        count <= count + 2'd1;
      end else if (pop && !push) begin
        count <= count - 2'd1;
      end
    end
  end

`ifdef ROUTE_INJECT_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  // count completed packets per port at the pop of their last flit, saturating
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (pop && out_last) begin
      if (!out_sel && cnt0_q != CNT_MAX) begin
        cnt0_q <= cnt0_q + 1'b1;
      end
      if (out_sel && cnt1_q != CNT_MAX) begin
        cnt1_q <= cnt1_q + 1'b1;
      end
    end
  end

  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;
`else
  assign pkt_cnt0 = '0;
  assign pkt_cnt1 = '0;
`endif

endmodule
